// File: rtl/park_sincos_cordic_if.sv
// -----------------------------------------------------------------------------
// park_sincos_cordic_if
// Request/result bundle between an angle source and the sin/cos CORDIC.
//   start     : request a conversion of theta (master -> slave)
//   theta     : unsigned electrical angle, 65536 = one turn (master -> slave)
//   busy      : conversion in progress (slave -> master)
//   done      : one-cycle pulse, new sin/cos valid (slave -> master)
//   sin_theta : signed Q15 sin(theta), held between conversions (slave -> master)
//   cos_theta : signed Q15 cos(theta), held between conversions (slave -> master)
// -----------------------------------------------------------------------------
interface park_sincos_cordic_if;
   logic               start;
   logic        [15:0] theta;
   logic               busy;
   logic               done;
   logic signed [15:0] sin_theta;
   logic signed [15:0] cos_theta;

   modport master (
      output start,
      output theta,
      input  busy,
      input  done,
      input  sin_theta,
      input  cos_theta
   );

   modport slave (
      input  start,
      input  theta,
      output busy,
      output done,
      output sin_theta,
      output cos_theta
   );
endinterface

// File: rtl/park_sincos_cordic.sv
// -----------------------------------------------------------------------------
// park_sincos_cordic
// Iterative rotation-mode CORDIC turning a 16-bit electrical angle into Q15
// sin/cos for the downstream Park transform. One micro-rotation per clock;
// results are registered and held until the next conversion or reset.
//   clk : system clock
//   rst : synchronous active-high reset (aborts a running conversion)
//   io  : slave side of park_sincos_cordic_if (start/theta in, busy/done and
//         sin_theta/cos_theta out)
// Parameters: ITER micro-rotations (12..18), XG x/y guard bits (>= 0),
// ZG angle guard bits (0..7).
// -----------------------------------------------------------------------------
module park_sincos_cordic #(
   parameter int ITER = 16,
   parameter int XG   = 2,
   parameter int ZG   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   park_sincos_cordic_if.slave  io
);

   localparam int W  = 16 + XG + 2;
   localparam int ZW = 16 + ZG;
   localparam int CW = $clog2(ITER);

   // Gain pre-compensation 0.6072529 * 2^(15+XG), rounded, in integer math.
   localparam longint X0_L = (longint'(6072529) * (longint'(1) << (15 + XG))
                              + longint'(5000000)) / longint'(10000000);
   localparam logic signed [W-1:0]  X0    = W'(X0_L);
   localparam logic signed [W:0]    RHALF = (W+1)'((longint'(1) << XG) >> 1);
   localparam logic signed [W:0]    QMAX  = (W+1)'(32767);
   localparam logic signed [W:0]    QMIN  = -QMAX;
   localparam logic signed [15:0]   ONE   = 16'sd32767;

   typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_FINISH} state_t;

   state_t                 state, state_nxt;
   logic        [CW-1:0]   iter;
   logic signed [W-1:0]    x, y;
   logic signed [ZW-1:0]   z;
   logic                   flip;
   logic                   flip_ld;
   logic signed [15:0]     z16;
   logic signed [ZW-1:0]   z_ld;
   logic                   last_iter;
   logic                   done_r;
   logic signed [15:0]     sin_r, cos_r;
   logic signed [15:0]     sin_sat, cos_sat;

   // atan(2^-i) in turns, stored as floor(value * 2^24). Rounding to the
   // 2^(16+ZG) grid from the floored value gives the exact rounded result.
   function automatic logic signed [ZW-1:0] atan_rom(input int i);
      longint v24;
      case (i)
         0:       v24 = 2097152;
         1:       v24 = 1238021;
         2:       v24 = 654136;
         3:       v24 = 332049;
         4:       v24 = 166669;
         5:       v24 = 83415;
         6:       v24 = 41718;
         7:       v24 = 20860;
         8:       v24 = 10430;
         9:       v24 = 5215;
         10:      v24 = 2607;
         11:      v24 = 1303;
         12:      v24 = 651;
         13:      v24 = 325;
         14:      v24 = 162;
         15:      v24 = 81;
         16:      v24 = 40;
         17:      v24 = 20;
         default: v24 = 0;
      endcase
      atan_rom = ZW'((v24 + (longint'(1) << (7 - ZG))) >> (8 - ZG));
   endfunction

   // Drop XG guard bits with round-half-up, then clamp to the symmetric
   // Q15 range so a later negation can never produce -32768.
   function automatic logic signed [15:0] rnd_sat(input logic signed [W-1:0] v);
      logic signed [W:0] r;
      r = (W+1)'(v) + RHALF;
      r = r >>> XG;
      if (r > QMAX)
         rnd_sat = ONE;
      else if (r < QMIN)
         rnd_sat = -ONE;
      else
         rnd_sat = r[15:0];
   endfunction

   // Quadrants 1 and 2 are rotated by theta-180 deg and negated at the end,
   // keeping the CORDIC input inside its +/-90 deg convergence range.
   assign flip_ld   = io.theta[15] ^ io.theta[14];
   assign z16       = flip_ld ? {~io.theta[15], io.theta[14:0]} : io.theta;
   assign z_ld      = ZW'(z16) <<< ZG;
   assign last_iter = (iter == CW'(ITER - 1));

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (io.start) state_nxt = S_ROTATE;
         S_ROTATE: if (last_iter) state_nxt = S_FINISH;
         S_FINISH: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Load / micro-rotation datapath
   always_ff @(posedge clk) begin
      case (state)
         S_IDLE: begin
            if (io.start) begin
               x    <= X0;
               y    <= '0;
               z    <= z_ld;
               flip <= flip_ld;
               iter <= '0;
            end
         end
         S_ROTATE: begin
            if (z[ZW-1]) begin
               x <= x + (y >>> iter);
               y <= y - (x >>> iter);
               z <= z + atan_rom(int'(iter));
            end else begin
               x <= x - (y >>> iter);
               y <= y + (x >>> iter);
               z <= z - atan_rom(int'(iter));
            end
            iter <= iter + 1'b1;
         end
         default: ;
      endcase
   end

   assign sin_sat = rnd_sat(y);
   assign cos_sat = rnd_sat(x);

   // Output registers; reset value is the angle-0 identity rotation.
   always_ff @(posedge clk) begin
      if (rst) begin
         done_r <= 1'b0;
         sin_r  <= '0;
         cos_r  <= ONE;
      end else begin
         done_r <= (state == S_FINISH);
         if (state == S_FINISH) begin
            sin_r <= flip ? -sin_sat : sin_sat;
            cos_r <= flip ? -cos_sat : cos_sat;
         end
      end
   end

   assign io.busy      = (state != S_IDLE);
   assign io.done      = done_r;
   assign io.sin_theta = sin_r;
   assign io.cos_theta = cos_r;

endmodule

// File: tb/tb_park_sincos_cordic.sv
// -----------------------------------------------------------------------------
// tb_park_sincos_cordic
// Directed and randomized bench for park_sincos_cordic. Expected sin/cos come
// from an ideal real-valued model round(32767*sin/cos(2*pi*theta/65536)) with
// a +/-4 LSB window; control timing is checked against fixed cycle counts.
// -----------------------------------------------------------------------------
module tb_park_sincos_cordic;

   localparam int LAT  = 17;
   localparam int TOL  = 4;
   localparam int NRND = 250;

   logic clk = 1'b0;
   logic rst;

   park_sincos_cordic_if dut_if ();

   park_sincos_cordic #(
      .ITER (16),
      .XG   (2),
      .ZG   (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .io  (dut_if.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_near(input string tag, input int obs, input int exp);
      int d;
      d = obs - exp;
      n_checks++;
      assert ((d >= -TOL && d <= TOL) === 1'b1) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d +/-%0d", tag, obs, exp, TOL);
      end
   endtask

   function automatic int q15_round(input real r);
      if (r >= 0.0)
         return $rtoi(r + 0.5);
      else
         return -$rtoi(-r + 0.5);
   endfunction

   function automatic int ideal_sin(input int th);
      real ang;
      ang = 2.0 * 3.14159265358979 * real'(th) / 65536.0;
      return q15_round(32767.0 * $sin(ang));
   endfunction

   function automatic int ideal_cos(input int th);
      real ang;
      ang = 2.0 * 3.14159265358979 * real'(th) / 65536.0;
      return q15_round(32767.0 * $cos(ang));
   endfunction

   task automatic check_result(input string tag, input int th);
      int s, c;
      s = int'(dut_if.sin_theta);
      c = int'(dut_if.cos_theta);
      check_near({tag, ".sin"}, s, ideal_sin(th));
      check_near({tag, ".cos"}, c, ideal_cos(th));
      check_eq({tag, ".no_neg_full"}, int'(s != -32768 && c != -32768), 1);
   endtask

   // Issues start for one edge, then waits (bounded) for done.
   // Returns with the done cycle visible, so a following call starts
   // back-to-back during the done cycle.
   task automatic run_conv(input int th, output int lat);
      dut_if.theta = th[15:0];
      dut_if.start = 1'b1;
      tick();
      dut_if.start = 1'b0;
      check_eq("busy_after_start", int'(dut_if.busy), 1);
      lat = 0;
      while (dut_if.done !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   initial begin
      int lat;
      int th;
      int ndone;
      int first;
      int dirs[5];
      int edges[7];

      dirs  = '{16'h4000, 16'h8000, 16'hC000, 16'h2000, 16'hE000};
      edges = '{16'h3FFF, 16'h4001, 16'h7FFF, 16'hBFFF, 16'hC001, 16'hFFFF, 16'h0001};

      // Reset held for three cycles
      rst          = 1'b1;
      dut_if.start = 1'b0;
      dut_if.theta = '0;
      repeat (3) tick();
      rst = 1'b0;
      check_eq("rst.busy", int'(dut_if.busy), 0);
      check_eq("rst.done", int'(dut_if.done), 0);
      check_eq("rst.sin", int'(dut_if.sin_theta), 0);
      check_eq("rst.cos", int'(dut_if.cos_theta), 32767);

      // First conversion at angle 0
      run_conv(0, lat);
      check_eq("t0.latency", lat, LAT);
      check_result("t0", 0);
      check_eq("t0.busy_at_done", int'(dut_if.busy), 0);
      tick();
      check_eq("t0.done_one_cycle", int'(dut_if.done), 0);
      check_result("t0.hold", 0);

      // Axis and diagonal angles
      foreach (dirs[k]) begin
         run_conv(dirs[k], lat);
         check_eq($sformatf("dir%0h.latency", dirs[k]), lat, LAT);
         check_result($sformatf("dir%0h", dirs[k]), dirs[k]);
      end
      tick();

      // start pulses while busy are ignored; outputs hold after done
      dut_if.theta = 16'h1555;
      dut_if.start = 1'b1;
      tick();
      ndone = 0;
      first = 0;
      for (int c = 1; c <= 30; c++) begin
         if (c == 5 || c == 10) begin
            dut_if.start = 1'b1;
            dut_if.theta = 16'hA000;
         end else begin
            dut_if.start = 1'b0;
         end
         tick();
         if (dut_if.done === 1'b1) begin
            ndone++;
            if (first == 0) first = c;
         end
      end
      check_eq("ign.first_done", first, LAT);
      check_eq("ign.done_count", ndone, 1);
      check_eq("ign.busy_idle", int'(dut_if.busy), 0);
      check_result("ign", 16'h1555);

      // Back-to-back: quadrant edges then random angles
      foreach (edges[k]) begin
         run_conv(edges[k], lat);
         check_eq($sformatf("edge%0h.latency", edges[k]), lat, LAT);
         check_result($sformatf("edge%0h", edges[k]), edges[k]);
      end
      for (int k = 0; k < NRND; k++) begin
         th = int'($urandom_range(0, 65535));
         run_conv(th, lat);
         check_eq($sformatf("rnd%0h.latency", th), lat, LAT);
         check_result($sformatf("rnd%0h", th), th);
      end
      tick();
      tick();

      // Reset during rotation aborts the conversion
      dut_if.theta = 16'h3000;
      dut_if.start = 1'b1;
      tick();
      dut_if.start = 1'b0;
      repeat (8) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("abort.busy", int'(dut_if.busy), 0);
      check_eq("abort.done", int'(dut_if.done), 0);
      check_eq("abort.sin", int'(dut_if.sin_theta), 0);
      check_eq("abort.cos", int'(dut_if.cos_theta), 32767);
      ndone = 0;
      for (int c = 0; c < 25; c++) begin
         tick();
         if (dut_if.done === 1'b1) ndone++;
      end
      check_eq("abort.no_done", ndone, 0);
      run_conv(16'h3000, lat);
      check_eq("post_abort.latency", lat, LAT);
      check_result("post_abort", 16'h3000);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
